// File: rtl/uart_tx_top.sv
// Memory-mapped 8N1 UART transmitter: small TX FIFO, programmable baud divisor,
// frame serialiser FSM and a level interrupt for "enabled, drained and idle".
module uart_tx_top #(
  parameter int               FIFO_DEPTH = 4,
  parameter int               DIV_W      = 16,
  parameter logic [DIV_W-1:0] DIV_RESET  = DIV_W'(868)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   shadow_q, shadow_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               en_q, en_d;
  logic               ovf_q, ovf_d;
  logic [DIV_W-1:0]   div_q, div_d;

  logic               full_s;
  logic               empty_s;
  logic               busy_s;
  logic               bit_end_s;
  logic               pop_s;
  logic               push_s;
  logic               push_ok_s;
  logic               ovf_set_s;
  logic [DIV_W-1:0]   eff_div_s;
  logic [7:0]         head_s;

  assign full_s    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_s   = (count_q == CNT_W'(0));
  assign busy_s    = (state_q != IDLE);
  assign eff_div_s = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
  assign bit_end_s = (cnt_q == (shadow_q - DIV_W'(1)));
  assign head_s    = mem_q[rd_ptr_q];

  // A pop happens when leaving IDLE or at the end of a stop bit with work queued.
  assign pop_s     = en_q & ~empty_s &
                     ((state_q == IDLE) | ((state_q == STOP) & bit_end_s));
  assign push_s    = we & (a == 2'd0);
  assign push_ok_s = push_s & (~full_s | pop_s);
  assign ovf_set_s = push_s & full_s & ~pop_s;

  assign tx  = tx_q;
  assign irq = en_q & empty_s & ~busy_s;

  // Serialiser next-state: start bit, 8 data bits LSB first, stop bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop_s) begin
          state_d  = START;
          cnt_d    = DIV_W'(0);
          bit_d    = 3'd0;
          shift_d  = head_s;
          shadow_d = eff_div_s;
          tx_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = DATA;
          cnt_d   = DIV_W'(0);
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_d = DIV_W'(0);
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_d = DIV_W'(0);
          if (pop_s) begin
            state_d  = START;
            bit_d    = 3'd0;
            shift_d  = head_s;
            shadow_d = eff_div_s;
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = DIV_W'(0);
        tx_d    = 1'b1;
      end
    endcase
  end

  // Register file and FIFO bookkeeping; an overflow set beats a same-edge clear.
  always_comb begin
    en_d     = en_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (we && (a == 2'd2)) begin
      div_d = wd[DIV_W-1:0];
    end else begin
      div_d = div_q;
    end
    if (we && (a == 2'd3)) begin
      en_d = wd[0];
      if (wd[1]) begin
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      en_d = en_q;
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s && !pop_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_s && !push_ok_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Read mux, combinational from the register select.
  always_comb begin
    rd = 32'h0000_0000;
    case (a)
      2'd0:    rd = 32'h0000_0000;
      2'd1:    rd = {27'd0, busy_s, ovf_q, full_s, empty_s, en_q};
      2'd2:    rd = 32'(div_q);
      2'd3:    rd = {31'd0, en_q};
      default: rd = 32'h0000_0000;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= DIV_W'(0);
      shadow_q <= DIV_W'(2);
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
      div_q    <= DIV_RESET;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
    end
  end

  // FIFO storage; stale entries are harmless because reset clears the pointers.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wd[7:0];
    end
  end

endmodule

// File: tb/tb_uart_tx_top.sv
// Scoreboard bench for uart_tx_top: a tx line monitor decodes frames, checks bit
// timing against the bench's own divisor model and pops expected bytes from a queue.
module tb_uart_tx_top;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we  = 1'b0;
  logic [1:0]  a   = 2'd0;
  logic [31:0] wd  = 32'd0;
  logic [31:0] rd;
  logic        tx;
  logic        irq;

  int          checks      = 0;
  int          failures    = 0;
  int          frames_done = 0;
  int          model_div   = 868;
  bit          abort       = 1'b0;
  logic [7:0]  sb_q[$];
  int          gap_q[$];

  uart_tx_top dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .a   (a),
    .wd  (wd),
    .rd  (rd),
    .tx  (tx),
    .irq (irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    a  = addr;
    wd = data;
    we = 1'b1;
    if (addr == 2'd2) model_div = int'(data[15:0]);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    sb_q.push_back(b);
    bus_write(2'd0, {24'd0, b});
  endtask

  task automatic check_reg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    a = addr;
    #1;
    v = rd;
    check_val(tag, v, exp);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && frames_done < target; i++) @(negedge clk);
    check_val(tag, frames_done, target);
  endtask

  // Line monitor: samples tx on every falling clock edge.
  initial begin : monitor
    int         idle_cnt;
    int         eff;
    int         glitch;
    bit         aborted;
    logic       mid, st, sp;
    logic [7:0] obs, exp_b;
    logic       smp[$];
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && !abort) begin
        gap_q.push_back(idle_cnt);
        idle_cnt = 0;
        eff = (model_div < 2) ? 2 : model_div;
        smp.delete();
        smp.push_back(tx);
        aborted = 1'b0;
        for (int k = 1; k < 10 * eff; k++) begin
          @(negedge clk);
          if (abort) begin
            aborted = 1'b1;
            break;
          end
          smp.push_back(tx);
        end
        if (!aborted) begin
          glitch = 0;
          obs = 8'h00;
          st = 1'b1;
          sp = 1'b0;
          for (int s = 0; s < 10; s++) begin
            mid = smp[s * eff + eff / 2];
            for (int j = 0; j < eff; j++) if (smp[s * eff + j] !== mid) glitch++;
            if (s == 0) st = mid;
            else if (s == 9) sp = mid;
            else obs[s - 1] = mid;
          end
          check_val("frame_start_stop", {30'd0, st, sp}, 32'd1);
          check_val("frame_timing", glitch, 0);
          if (sb_q.size() == 0) begin
            check_val("sb_underflow", sb_q.size(), 1);
          end else begin
            exp_b = sb_q.pop_front();
            check_val("frame_byte", {24'd0, obs}, {24'd0, exp_b});
          end
          frames_done++;
        end
      end else begin
        idle_cnt++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          busy_n;
    int          lows;
    bit          seen;
    logic [31:0] v;

    // Reset state
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_tx", tx, 1);
    check_val("rst_irq", irq, 0);
    check_reg("rst_status", 2'd1, 32'h02);
    check_reg("rst_div", 2'd2, 32'd868);
    check_reg("rst_ctrl", 2'd3, 32'd0);
    check_reg("rst_data", 2'd0, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: single frame 0x55 at DIV=4, busy for 40 cycles, then irq
    bus_write(2'd2, 32'd4);
    bus_write(2'd3, 32'd1);
    push_byte(8'h55);
    busy_n = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      a = 2'd1;
      #1;
      v = rd;
      if (v[4]) begin
        busy_n++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
      @(negedge clk);
    end
    check_val("t1_busy_cycles", busy_n, 40);
    check_val("t1_irq", irq, 1);
    check_val("t1_frames", frames_done, 1);
    check_reg("t1_status", 2'd1, 32'h03);

    // 2: overflow with en=0, then four back-to-back frames, then W1C of ovf
    bus_write(2'd3, 32'd0);
    for (int b = 1; b <= 4; b++) push_byte(8'(b));
    bus_write(2'd0, 32'h05);
    check_reg("t2_status_full", 2'd1, 32'h0C);
    check_val("t2_irq_off", irq, 0);
    gap_q.delete();
    bus_write(2'd3, 32'd1);
    wait_frames("t2_frames", 5, 400);
    repeat (3) @(negedge clk);
    check_reg("t2_status_done", 2'd1, 32'h0B);
    check_val("t2_gap_count", gap_q.size(), 4);
    if (gap_q.size() >= 4) begin
      for (int i = 1; i < 4; i++) check_val("t2_gap", gap_q[i], 0);
    end
    bus_write(2'd3, 32'd3);
    check_reg("t2_ovf_clear", 2'd1, 32'h03);

    // 3: divisor clamp, raw readback
    bus_write(2'd2, 32'd0);
    check_reg("t3_div0", 2'd2, 32'd0);
    bus_write(2'd2, 32'hFFFF_0001);
    check_reg("t3_div1", 2'd2, 32'd1);
    push_byte(8'hA5);
    wait_frames("t3_frames", 6, 200);
    repeat (3) @(negedge clk);

    // 4: mid-frame DIV change only affects the next frame
    bus_write(2'd2, 32'd8);
    gap_q.delete();
    push_byte(8'hFF);
    push_byte(8'h3C);
    repeat (20) @(negedge clk);
    bus_write(2'd2, 32'd3);
    wait_frames("t4_frames", 8, 300);
    check_val("t4_gap_count", gap_q.size(), 2);
    if (gap_q.size() >= 2) check_val("t4_gap", gap_q[1], 0);
    repeat (3) @(negedge clk);

    // 6: push while full on the exact pop edge (end of the first frame)
    bus_write(2'd2, 32'd2);
    push_byte(8'hC1);
    push_byte(8'h12);
    push_byte(8'h34);
    push_byte(8'h56);
    push_byte(8'h78);
    repeat (16) @(negedge clk);
    check_reg("t6_status_full", 2'd1, 32'h15);
    push_byte(8'h9A);
    check_reg("t6_status_same_edge", 2'd1, 32'h15);
    wait_frames("t6_frames", 14, 400);
    repeat (3) @(negedge clk);

    // 5: reset in the middle of the data bits
    bus_write(2'd2, 32'd4);
    push_byte(8'h33);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    model_div = 868;
    check_val("t5_tx", tx, 1);
    check_reg("t5_status", 2'd1, 32'h02);
    check_reg("t5_div", 2'd2, 32'd868);
    check_reg("t5_ctrl", 2'd3, 32'd0);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check_val("t5_tx_quiet", lows, 0);
    check_val("t5_frames", frames_done, 14);
    abort = 1'b0;

    check_val("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
